// File: rtl/axi_stream_output_pkg.sv
// Shared pipeline constants for the output stage: vector geometry and a
// helper that picks one character out of a packed vector.
package axi_stream_output_pkg;

  localparam int N        = 10;
  localparam int CHAR_LEN = 8;
  localparam int VEC_W    = N * CHAR_LEN;
  localparam int IDX_W    = (N > 1) ? $clog2(N) : 1;

  function automatic logic [CHAR_LEN-1:0] char_at(input logic [VEC_W-1:0] vec,
                                                  input logic [IDX_W-1:0] k);
    char_at = vec[int'(k) * CHAR_LEN +: CHAR_LEN];
  endfunction

endpackage

// File: rtl/axi_stream_output.sv
// Output stage: captures an N-character vector on a run request and streams it
// LSB character first over an AXI4-Stream master, flagging the final beat.
module axi_stream_output
  import axi_stream_output_pkg::*;
(
  input  logic                ACLK,
  input  logic                ARESETN,
  input  logic                run,
  input  logic [VEC_W-1:0]    d,
  output logic                valid,
  output logic [CHAR_LEN-1:0] M_AXIS_TDATA,
  output logic                M_AXIS_TVALID,
  output logic                M_AXIS_TLAST,
  input  logic                M_AXIS_TREADY
);

  typedef enum logic [0:0] {IDLE = 1'b0, SEND = 1'b1} state_t;

  state_t              state_r, state_s;
  logic [VEC_W-1:0]    buf_r, buf_s;
  logic [IDX_W-1:0]    idx_r, idx_s, next_idx_s;
  logic                valid_r, valid_s;
  logic                tvalid_r, tvalid_s;
  logic                tlast_r, tlast_s;
  logic [CHAR_LEN-1:0] tdata_r, tdata_s;
  logic                capture_s, beat_s;

  // Next-state, buffer and output-register values.
  always_comb begin
    state_s    = state_r;
    buf_s      = buf_r;
    idx_s      = idx_r;
    tvalid_s   = tvalid_r;
    tlast_s    = tlast_r;
    tdata_s    = tdata_r;
    next_idx_s = idx_r + IDX_W'(1);
    // valid high means the current run request was already served
    capture_s  = (state_r == IDLE) && run && !valid_r;
    beat_s     = tvalid_r && M_AXIS_TREADY;

    case (state_r)
      IDLE: begin
        if (capture_s) begin
          state_s  = SEND;
          buf_s    = d;
          idx_s    = {IDX_W{1'b0}};
          tvalid_s = 1'b1;
          tdata_s  = char_at(d, {IDX_W{1'b0}});
          tlast_s  = (N == 1);
        end else begin
          state_s = IDLE;
        end
      end
      SEND: begin
        if (beat_s && tlast_r) begin
          state_s  = IDLE;
          tvalid_s = 1'b0;
          tlast_s  = 1'b0;
        end else if (beat_s) begin
          idx_s   = next_idx_s;
          tdata_s = char_at(buf_r, next_idx_s);
          tlast_s = (next_idx_s == IDX_W'(N - 1));
        end else begin
          state_s = SEND;
        end
      end
      default: begin
        state_s  = IDLE;
        tvalid_s = 1'b0;
        tlast_s  = 1'b0;
      end
    endcase

    if (!run) begin
      valid_s = 1'b0;
    end else if (capture_s) begin
      valid_s = 1'b1;
    end else begin
      valid_s = valid_r;
    end
  end

  // State and output registers with synchronous active-low reset.
  always_ff @(posedge ACLK) begin
    if (!ARESETN) begin
      state_r  <= IDLE;
      buf_r    <= {VEC_W{1'b0}};
      idx_r    <= {IDX_W{1'b0}};
      valid_r  <= 1'b0;
      tvalid_r <= 1'b0;
      tlast_r  <= 1'b0;
      tdata_r  <= {CHAR_LEN{1'b0}};
    end else begin
      state_r  <= state_s;
      buf_r    <= buf_s;
      idx_r    <= idx_s;
      valid_r  <= valid_s;
      tvalid_r <= tvalid_s;
      tlast_r  <= tlast_s;
      tdata_r  <= tdata_s;
    end
  end

  assign valid         = valid_r;
  assign M_AXIS_TDATA  = tdata_r;
  assign M_AXIS_TVALID = tvalid_r;
  assign M_AXIS_TLAST  = tlast_r;

endmodule

// File: tb/tb_axi_stream_output.sv
// Directed self-checking bench for axi_stream_output.
module tb_axi_stream_output;
  import axi_stream_output_pkg::*;

  logic                ACLK = 1'b0;
  logic                ARESETN;
  logic                run;
  logic [VEC_W-1:0]    d;
  logic                valid;
  logic [CHAR_LEN-1:0] M_AXIS_TDATA;
  logic                M_AXIS_TVALID;
  logic                M_AXIS_TLAST;
  logic                M_AXIS_TREADY;

  int n_assert = 0;
  int n_fail   = 0;

  axi_stream_output dut (
    .ACLK          (ACLK),
    .ARESETN       (ARESETN),
    .run           (run),
    .d             (d),
    .valid         (valid),
    .M_AXIS_TDATA  (M_AXIS_TDATA),
    .M_AXIS_TVALID (M_AXIS_TVALID),
    .M_AXIS_TLAST  (M_AXIS_TLAST),
    .M_AXIS_TREADY (M_AXIS_TREADY)
  );

  always #5 ACLK = ~ACLK;

  task automatic step();
    @(posedge ACLK);
    #1;
  endtask

  task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    n_assert++;
    assert (obs === exp) else begin
      n_fail++;
      $error("FAIL %s: observed %0h expected %0h", tag, obs, exp);
    end
  endtask

  // Builds a vector whose element k is base+k.
  function automatic logic [VEC_W-1:0] ramp(input logic [7:0] base);
    logic [VEC_W-1:0] v;
    v = '0;
    for (int k = 0; k < N; k++) v[k*CHAR_LEN +: CHAR_LEN] = base + 8'(k);
    return v;
  endfunction

  // Streams a whole vector with TREADY held high, checking order and TLAST.
  task automatic stream_all(input logic [7:0] base, input string tag);
    for (int k = 0; k < N; k++) begin
      chk({tag, "_tvalid"}, 32'(M_AXIS_TVALID), 32'd1);
      chk({tag, "_tdata"}, 32'(M_AXIS_TDATA), 32'(base + 8'(k)));
      chk({tag, "_tlast"}, 32'(M_AXIS_TLAST), (k == N - 1) ? 32'd1 : 32'd0);
      step();
    end
    chk({tag, "_tvalid_end"}, 32'(M_AXIS_TVALID), 32'd0);
    chk({tag, "_tlast_end"}, 32'(M_AXIS_TLAST), 32'd0);
  endtask

  initial begin
    int k;
    logic rdy;

    // Reset
    ARESETN = 1'b0; run = 1'b0; d = '0; M_AXIS_TREADY = 1'b0;
    step(); step();
    chk("rst_valid", 32'(valid), 32'd0);
    chk("rst_tvalid", 32'(M_AXIS_TVALID), 32'd0);
    chk("rst_tlast", 32'(M_AXIS_TLAST), 32'd0);
    chk("rst_tdata", 32'(M_AXIS_TDATA), 32'd0);

    // Capture with TREADY low, run held
    ARESETN = 1'b1;
    d = {8'hff, {9{8'h01}}};
    run = 1'b1;
    step();
    chk("cap_valid", 32'(valid), 32'd1);
    chk("cap_tvalid", 32'(M_AXIS_TVALID), 32'd1);
    chk("cap_tdata", 32'(M_AXIS_TDATA), 32'h01);
    chk("cap_tlast", 32'(M_AXIS_TLAST), 32'd0);
    for (int i = 0; i < 5; i++) begin
      step();
      chk("hold_valid", 32'(valid), 32'd1);
      chk("hold_tvalid", 32'(M_AXIS_TVALID), 32'd1);
      chk("hold_tdata", 32'(M_AXIS_TDATA), 32'h01);
    end
    run = 1'b0;
    step();
    chk("drop_valid", 32'(valid), 32'd0);
    chk("drop_tvalid", 32'(M_AXIS_TVALID), 32'd1);

    // Stream with TREADY high: nine 01 beats then ff with TLAST
    M_AXIS_TREADY = 1'b1;
    for (int i = 0; i < N; i++) begin
      chk("s1_tdata", 32'(M_AXIS_TDATA), (i == N - 1) ? 32'hff : 32'h01);
      chk("s1_tlast", 32'(M_AXIS_TLAST), (i == N - 1) ? 32'd1 : 32'd0);
      step();
    end
    chk("s1_tvalid_end", 32'(M_AXIS_TVALID), 32'd0);

    // Backpressure: TREADY toggles every cycle
    M_AXIS_TREADY = 1'b0;
    d = ramp(8'h00);
    run = 1'b1;
    step();
    chk("bp_cap_tdata", 32'(M_AXIS_TDATA), 32'h00);
    run = 1'b0;
    k = 0;
    rdy = 1'b0;
    for (int cyc = 0; cyc < 100 && k < N; cyc++) begin
      M_AXIS_TREADY = rdy;
      chk("bp_tvalid", 32'(M_AXIS_TVALID), 32'd1);
      chk("bp_tdata", 32'(M_AXIS_TDATA), 32'(k));
      chk("bp_tlast", 32'(M_AXIS_TLAST), (k == N - 1) ? 32'd1 : 32'd0);
      step();
      if (rdy) k++;
      rdy = ~rdy;
    end
    chk("bp_beats", 32'(k), 32'(N));
    chk("bp_tvalid_end", 32'(M_AXIS_TVALID), 32'd0);
    chk("bp_valid", 32'(valid), 32'd0);

    // New run mid-stream is ignored until the FSM is back in IDLE
    M_AXIS_TREADY = 1'b0;
    d = ramp(8'h10);
    run = 1'b1;
    step();
    chk("busy_cap_tdata", 32'(M_AXIS_TDATA), 32'h10);
    run = 1'b0;
    step();
    M_AXIS_TREADY = 1'b1;
    for (int i = 0; i < N; i++) begin
      if (i == 3) begin
        run = 1'b1;
        d = ramp(8'h20);
      end
      chk("busy_tdata", 32'(M_AXIS_TDATA), 32'(8'h10 + 8'(i)));
      chk("busy_tlast", 32'(M_AXIS_TLAST), (i == N - 1) ? 32'd1 : 32'd0);
      step();
    end
    chk("busy_tvalid_end", 32'(M_AXIS_TVALID), 32'd0);
    step();
    chk("recap_valid", 32'(valid), 32'd1);
    stream_all(8'h20, "s2");
    step();
    chk("held_no_recap", 32'(M_AXIS_TVALID), 32'd0);
    run = 1'b0;
    step();

    // Mid-stream reset after beat 3
    d = ramp(8'h30);
    run = 1'b1;
    step();
    run = 1'b0;
    for (int i = 0; i < 4; i++) begin
      chk("mr_tdata", 32'(M_AXIS_TDATA), 32'(8'h30 + 8'(i)));
      step();
    end
    ARESETN = 1'b0;
    step();
    chk("mr_tvalid", 32'(M_AXIS_TVALID), 32'd0);
    chk("mr_tlast", 32'(M_AXIS_TLAST), 32'd0);
    chk("mr_tdata0", 32'(M_AXIS_TDATA), 32'd0);
    ARESETN = 1'b1;
    run = 1'b1;
    step();
    chk("mr_recap_valid", 32'(valid), 32'd1);
    stream_all(8'h30, "s3");

    $display("End of test - %0d assertions evaluated, %0d failures", n_assert, n_fail);
    $finish;
  end

endmodule

// File: doc/axi_stream_output.md
Name: axi_stream_output

Overview:
- Output stage of the inference pipeline. On a `run` request it captures an N-character result vector `d` and serialises it onto an AXI4-Stream master interface, one character per beat.
- It asserts `TLAST` on the final character.
- It uses the pipeline's `run`/`valid` handshake on the upstream side.

Parameters:
- N, 10: number of characters per vector (shared constant `N`).
- CHAR_LEN, 8: bits per character and TDATA width (shared constant `CHAR_LEN`).

Ports:
- ACLK  input  1  clock; all logic is on the rising edge.
- ARESETN  input  1  reset, synchronous, active-low.
- run  input  1  upstream request: `d` is valid and may be captured.
- d  input  N*CHAR_LEN  character vector; element k is `d[k*CHAR_LEN +: CHAR_LEN]`.
- valid  output  1  upstream acknowledge: vector captured.
- M_AXIS_TDATA  output  CHAR_LEN  current character.
- M_AXIS_TVALID  output  1  beat valid.
- M_AXIS_TLAST  output  1  final beat of the vector.
- M_AXIS_TREADY  input  1  downstream ready.

Behaviour:
- Clocking and reset: one clock, ACLK. Reset is synchronous, active-low, on ARESETN.
- Reset values: state=IDLE, buffer=0, index=0, valid=0, M_AXIS_TVALID=0, M_AXIS_TLAST=0, M_AXIS_TDATA=0.
- All outputs are registered. No combinational path from inputs to outputs.
- State machine, IDLE → SEND → IDLE.
- IDLE, with run=1 and valid=0:
  - latch `d` into an internal buffer; index←0;
  - next cycle: state=SEND, valid=1, M_AXIS_TVALID=1, M_AXIS_TDATA=element 0.
  - TLAST=1 immediately if N==1.
- IDLE, with run=1 and valid=1: this is the same request still held, so nothing is captured.
- valid behaviour:
  - stays 1 while run stays 1;
  - clears on the first clock edge with run=0.
  - A new capture requires run to be seen 0 first, then 1 again, with the FSM back in IDLE.
- SEND, beat transfer: a beat transfers on any edge with TVALID & TREADY.
- SEND, non-last beat transferred:
  - index←index+1;
  - TDATA←element index+1;
  - TLAST←(index+1 == N-1).
- SEND, last beat (TLAST=1) transferred: TVALID←0, TLAST←0, state←IDLE.
- SEND, TREADY=0: TDATA, TVALID and TLAST hold stable (AXI rule). TVALID never drops before the beat transfers.
- Beat ordering: element 0 (the LSB slice) first, element N-1 (the MSB slice) last. Exactly one TLAST per vector.
- Throughput: one beat per cycle while TREADY=1. N beats take N cycles from the first TVALID&TREADY edge.
- Run handling during SEND: `run` and `d` are ignored; the buffer is frozen. A run still high when the FSM returns to IDLE is honoured only if valid has been cleared, i.e. run was seen low in between.
- Reset mid-stream: the stream is abandoned, TVALID drops next edge, and no TLAST is issued.
- Index counter width: clog2(N), minimum 1 bit.

Decomposition:
- `N` and `CHAR_LEN` come from the shared constants header/package used by all pipeline stages. No local redefinition.
- The FSM state encoding (IDLE, SEND) stays local.
- Single module; no sub-module is required. Optionally, the capture buffer plus index mux can be a `char_serializer` sub-module.

Test Plan:
- Reset: hold ARESETN=0 for 2 cycles → valid=0, TVALID=0, TLAST=0, TDATA=0.
- Capture, TREADY=0: d={8'hff, nine×8'h01}, run=1 → valid=1 one cycle later; TVALID=1, TDATA=8'h01. Hold run 5 cycles → no change. Drop run → valid=0 next edge, TVALID still 1.
- Stream, TREADY=1: TDATA=8'h01 on 9 consecutive beats with TLAST=0. 10th beat TDATA=8'hff with TLAST=1. TVALID=0 the cycle after.
- Backpressure: toggle TREADY every cycle with d={8'h09,…,8'h00} → beats 0..9 in order, no duplicates or drops. TDATA is stable whenever TREADY=0; exactly one TLAST, on 8'h09.
- Run ignored while busy: assert a new run with different `d` mid-stream → current stream completes unchanged. The new vector is captured only after run returns low, then high, in IDLE.
- Mid-stream reset: ARESETN=0 after beat 3 → TVALID=0 next edge, no TLAST. Then run=1 → fresh stream restarts at element 0.
